dlist_swap_ctrl: RTL
====================

Name: dlist_swap_ctrl

Overview:
- Ping-pong controller for the two display-list RAM banks that sit between memory_manage (writer) and the vector line-drawer (reader).
- Routes the writer's address/data stream into the back bank and the reader's address into the front bank.
- Swaps the banks when both sides are ready: the writer has finished a frame, the reader has finished its frame, and the minimum frame period has elapsed.
- Drives memory_manage's halt input so that a new frame is rebuilt only after a swap.

Parameters:
ADR_WIDTH, 16, display-list address width.
DATAWIDTH, 18, display-list word width ({x[7:0], y[7:0], line, pos}).
DLIST_DEPTH, 4096, words per bank; writes at or above this address are dropped.
MIN_FRAME_CYCLES, 1000000, minimum clk cycles between consecutive swaps (frame-rate cap); must be ≥ 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_go  in  1  memory_manage go; high = display list complete, writer parked
wr_adr  in  ADR_WIDTH  memory_manage adrWRITE
wr_data  in  DATAWIDTH  memory_manage dataWRITE
halt  out  1  to memory_manage halt
rd_adr  in  ADR_WIDTH  line-drawer read address
rd_data  out  DATAWIDTH  front-bank read data (1-cycle RAM latency, passed through)
rd_frame_done  in  1  single-cycle pulse: reader consumed terminator word
rd_start  out  1  single-cycle pulse: new front bank valid, reader may start at address 0
front_sel  out  1  bank currently read by the reader
overflow  out  1  sticky: a write was dropped because wr_adr ≥ DLIST_DEPTH
bank0_we, bank1_we  out  1  bank write enables
bank0_adr, bank1_adr  out  ADR_WIDTH  bank addresses
bank0_din, bank1_din  out  DATAWIDTH  bank write data
bank0_dout, bank1_dout  in  DATAWIDTH  bank read data

Behaviour:
- Reset (sync, rst=1) sets these values, all taking effect the next edge:
  - state=FILL, front_sel=0, halt=0, rd_start=0, overflow=0.
  - rd_busy=0, front_valid=0.
  - Frame timer loaded with MIN_FRAME_CYCLES−1 and counting down.
- Reset mid-operation aborts any fill or swap; the back bank content is discarded. The writer shares rst.
- Bank routing is combinational from the registered front_sel:
  - Back bank (!front_sel) takes adr=wr_adr, din=wr_data.
  - Front bank takes adr=rd_adr.
  - rd_data = front-bank dout.
  - Front-bank we=0 always.
- Back-bank we = (state==FILL) & !wr_go & (wr_adr < DLIST_DEPTH).
  - If (state==FILL) & !wr_go & (wr_adr ≥ DLIST_DEPTH), overflow is set; it is cleared only by rst.
- rd_busy is set on the rd_start cycle and cleared on rd_frame_done.
  - rd_frame_done while !rd_busy is ignored.
  - rd_start and rd_frame_done never coincide (rd_start exists only in SWAP, and the reader is idle then).
- Frame timer:
  - Decrements to 0 and holds at 0.
  - Reloads to MIN_FRAME_CYCLES−1 in SWAP.
  - timer_done = (count==0).
- States:
  - FILL: halt=0; writer builds the list into the back bank. Go to FULL when wr_go=1.
  - FULL: halt=1 (writer parks in DONE). Go to SWAP when timer_done & (!rd_busy | rd_frame_done). A same-cycle rd_frame_done counts as idle.
  - SWAP (1 cycle):
    - front_sel toggles and front_valid←1, both effective next cycle.
    - rd_start=1 registered, so it appears the cycle after SWAP, aligned with the new front_sel.
    - halt=0, so the writer moves DONE→WAIT_FRAME_DONE. Go to KICK.
  - KICK (1 cycle): halt=1, so the writer moves WAIT_FRAME_DONE→RESET. Go to FILL.
- Outputs halt and rd_start are registered; the halt value listed per state is what is driven while in that state.
- Writer handshake timing:
  - In FILL the writer's terminator word lands one cycle before wr_go rises, so it is written.
  - Words presented while wr_go=1 are never written.
- The reader never starts before the first valid frame: front_valid=0 ⇒ no rd_start. The first SWAP occurs after the first fill and timer_done.
- A reader that never pulses rd_frame_done stalls the controller in FULL indefinitely. This is by design; there is no timeout.

Decomposition:
- vector_pkg gets:
  - dlist_state_t (enum logic [1:0]: FILL=0, FULL=1, SWAP=2, KICK=3).
  - DLIST_DEPTH.
  - DLIST_TERM = {8'd0, 8'd0, 1'b1, 1'b1}, the terminator word.
- One sub-module: frame_rate_timer.
  - Parameter: MIN_FRAME_CYCLES.
  - Ports: clk, rst, reload, done.
  - Internal down-counter sized $clog2(MIN_FRAME_CYCLES+1).

Test Plan:
- Reset then idle reader, MIN_FRAME_CYCLES=8, writer model writes 0..5 then raises wr_go → back bank1 holds words 0..5 incl. terminator at 5. 8 cycles after reset, SWAP: front_sel=1, one rd_start pulse, halt sequence 1→0→1 over FULL/SWAP/KICK.
- Reader busy (rd_start issued, no rd_frame_done) with wr_go=1 → stays FULL, halt=1, no writes. Pulse rd_frame_done → SWAP on that same cycle, front_sel toggles next cycle.
- rd_frame_done pulse while timer count=3 → SWAP exactly when count reaches 0, not before.
- wr_adr=4096 with DLIST_DEPTH=4096 in FILL → both bank we=0, overflow=1 and sticky until rst.
- wr_adr/wr_data changing during FULL/SWAP/KICK (wr_go=1) → no bank we asserted; front bank contents unchanged (readback at rd_adr 0..5 matches prior frame).
- rst asserted in FULL → next cycle state=FILL, halt=0, front_sel=0, front_valid=0, no rd_start until a full new frame plus timer.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector display-list path.
package vector_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    SWAP = 2'd2,
    KICK = 2'd3
  } dlist_state_t;

  localparam int unsigned DLIST_DEPTH = 4096;

  // Terminator word: {x, y, line, pos}
  localparam logic [17:0] DLIST_TERM = {8'd0, 8'd0, 1'b1, 1'b1};

endpackage

// File: rtl/frame_rate_timer.sv
// Minimum-frame-period down-counter: counts to zero and holds there,
// reload restarts the period.
module frame_rate_timer #(
  parameter int unsigned MIN_FRAME_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic done
);

  localparam int unsigned CW = $clog2(MIN_FRAME_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(MIN_FRAME_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: reload, else decrement until zero.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = RELOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, reset to a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RELOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/dlist_swap_ctrl.sv
// Ping-pong controller for the two display-list banks: writer fills the
// back bank, reader scans the front bank, banks swap when both are done
// and the minimum frame period has elapsed.
module dlist_swap_ctrl
  import vector_pkg::*;
#(
  parameter int unsigned ADR_WIDTH        = 16,
  parameter int unsigned DATAWIDTH        = 18,
  parameter int unsigned DLIST_DEPTH      = vector_pkg::DLIST_DEPTH,
  parameter int unsigned MIN_FRAME_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_go,
  input  logic [ADR_WIDTH-1:0] wr_adr,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 halt,
  input  logic [ADR_WIDTH-1:0] rd_adr,
  output logic [DATAWIDTH-1:0] rd_data,
  input  logic                 rd_frame_done,
  output logic                 rd_start,
  output logic                 front_sel,
  output logic                 overflow,
  output logic                 bank0_we,
  output logic                 bank1_we,
  output logic [ADR_WIDTH-1:0] bank0_adr,
  output logic [ADR_WIDTH-1:0] bank1_adr,
  output logic [DATAWIDTH-1:0] bank0_din,
  output logic [DATAWIDTH-1:0] bank1_din,
  input  logic [DATAWIDTH-1:0] bank0_dout,
  input  logic [DATAWIDTH-1:0] bank1_dout
);

  localparam logic [ADR_WIDTH:0] DEPTH_LIM = (ADR_WIDTH + 1)'(DLIST_DEPTH);

  dlist_state_t state_q, state_d;
  logic front_sel_q, front_sel_d;
  logic halt_q, halt_d;
  logic rd_start_q, rd_start_d;
  logic overflow_q, overflow_d;
  logic rd_busy_q, rd_busy_d;
  logic front_valid_q, front_valid_d;
  logic timer_done, timer_reload;
  logic in_range, wr_en;

  frame_rate_timer #(
    .MIN_FRAME_CYCLES(MIN_FRAME_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .reload(timer_reload),
    .done  (timer_done)
  );

  assign in_range = ({1'b0, wr_adr} < DEPTH_LIM);
  assign wr_en    = (state_q == FILL) && !wr_go && in_range;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      front_sel_q   <= 1'b0;
      halt_q        <= 1'b0;
      rd_start_q    <= 1'b0;
      overflow_q    <= 1'b0;
      rd_busy_q     <= 1'b0;
      front_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      halt_q        <= halt_d;
      rd_start_q    <= rd_start_d;
      overflow_q    <= overflow_d;
      rd_busy_q     <= rd_busy_d;
      front_valid_q <= front_valid_d;
    end
  end

  // Next state: a same-cycle rd_frame_done counts as reader idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (wr_go) state_d = FULL;
      FULL: if (timer_done && (!rd_busy_q || rd_frame_done)) state_d = SWAP;
      SWAP: state_d = KICK;
      KICK: state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output/next-register values; halt is registered from the next state
  // so the value seen in each state is the one that state asks for.
  always_comb begin
    halt_d        = (state_d == FULL) || (state_d == KICK);
    front_sel_d   = (state_q == SWAP) ? !front_sel_q : front_sel_q;
    front_valid_d = front_valid_q || (state_q == SWAP);
    rd_start_d    = (state_q == SWAP) && front_valid_d;
    timer_reload  = (state_q == SWAP);
    overflow_d    = overflow_q || ((state_q == FILL) && !wr_go && !in_range);
    rd_busy_d     = rd_busy_q;
    if (rd_start_q) begin
      rd_busy_d = 1'b1;
    end else if (rd_frame_done) begin
      rd_busy_d = 1'b0;
    end
  end

  // Bank routing: back bank is !front_sel, front bank is read-only.
  assign bank0_we  = front_sel_q && wr_en;
  assign bank1_we  = !front_sel_q && wr_en;
  assign bank0_adr = front_sel_q ? wr_adr : rd_adr;
  assign bank1_adr = front_sel_q ? rd_adr : wr_adr;
  assign bank0_din = wr_data;
  assign bank1_din = wr_data;
  assign rd_data   = front_sel_q ? bank1_dout : bank0_dout;

  assign halt      = halt_q;
  assign rd_start  = rd_start_q;
  assign front_sel = front_sel_q;
  assign overflow  = overflow_q;

endmodule
